// File: rtl/tim_hfsm_if.sv
// rtl/tim_hfsm_if.sv - signal bundle between the horizontal timing FSM and its neighbours
interface tim_hfsm_if;
    logic        vact;
    logic [13:0] adc_d;
    logic        hen;
    logic        clamp;
    logic        busy;
    logic        pix_valid;
    logic [13:0] pix_data;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        sof;
    logic        eol;
    logic        line_err;

    // master: the timing FSM itself
    modport master (
        input  vact, adc_d,
        output hen, clamp, busy, pix_valid, pix_data, pix_x, pix_y, sof, eol, line_err
    );

    // slave: vertical FSM / ADC on the input side, CCD driver and frame writer on the output side
    modport slave (
        output vact, adc_d,
        input  hen, clamp, busy, pix_valid, pix_data, pix_x, pix_y, sof, eol, line_err
    );
endinterface

// File: rtl/tim_hfsm.sv
// rtl/tim_hfsm.sv - horizontal timing and pixel-capture FSM
module tim_hfsm #(
    parameter int H_DUMMY   = 12,
    parameter int H_ACTIVE  = 2472,
    parameter int H_OVER    = 8,
    parameter int FRAME_GAP = 1024,
    parameter int ADC_LAT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    tim_hfsm_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMMY,
        S_ACTIVE,
        S_OVER,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        v;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        eol;
    } strobe_t;

    localparam logic [11:0] DUMMY_LAST  = 12'(H_DUMMY - 1);
    localparam logic [11:0] ACTIVE_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] OVER_LAST   = 12'(H_OVER - 1);
    localparam logic [11:0] LINE_MAX    = 12'd4095;
    // one bit wider than the other counters so FRAME_GAP = 4096 still saturates correctly
    localparam logic [12:0] GAP_MAX     = 13'(FRAME_GAP);

    logic        vact_q, vact_prev_q;
    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] line_q, line_d;
    logic [12:0] gap_q, gap_d;
    logic        frame_q, frame_d;
    logic        hen_q, hen_d;
    logic        clamp_q, clamp_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic        start;
    logic        abort;
    strobe_t     s0;
    strobe_t     feed;

    logic        pv_q, pv_d;
    logic [13:0] data_q, data_d;
    logic [11:0] px_q, px_d;
    logic [11:0] py_q, py_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;

    assign start = vact_q & ~vact_prev_q;
    assign abort = ~vact_q & (state_q inside {S_DUMMY, S_ACTIVE, S_OVER});

    // strobe for the current ACTIVE cycle; an aborting line never gets its eol
    always_comb begin
        s0.v   = (state_q == S_ACTIVE);
        s0.x   = cnt_q;
        s0.y   = line_q;
        s0.sof = (state_q == S_ACTIVE) & frame_q & (cnt_q == 12'd0);
        s0.eol = (state_q == S_ACTIVE) & (cnt_q == ACTIVE_LAST) & ~abort;
    end

    // line state machine: next state, counters and registered line-level outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_DUMMY;
                        cnt_d   = 12'd0;
                        gap_d   = 13'd0;
                        if (gap_q >= GAP_MAX) begin
                            line_d  = 12'd0;
                            frame_d = 1'b1;
                        end
                    end else if (!vact_q && gap_q < GAP_MAX) begin
                        gap_d = gap_q + 13'd1;
                    end
                end
                S_DUMMY: begin
                    if (cnt_q == DUMMY_LAST) begin
                        state_d = S_ACTIVE;
                        cnt_d   = 12'd0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_ACTIVE: begin
                    if (cnt_q == ACTIVE_LAST) begin
                        state_d = S_OVER;
                        cnt_d   = 12'd0;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_OVER: begin
                    if (cnt_q == OVER_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = 12'd0;
                        line_d  = (line_q == LINE_MAX) ? line_q : line_q + 12'd1;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_DONE: begin
                    // a re-rise while still here is ignored: only vact_q low leaves DONE
                    if (!vact_q) begin
                        state_d = S_IDLE;
                        if (gap_q < GAP_MAX) begin
                            gap_d = gap_q + 13'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // the frame flag is consumed by the x=0 strobe, even if the line aborts right there
        if (state_q == S_ACTIVE && cnt_q == 12'd0) begin
            frame_d = 1'b0;
        end
    end

    // outputs follow the next state so they line up with the state register
    always_comb begin
        hen_d   = (state_d inside {S_DUMMY, S_ACTIVE, S_OVER});
        clamp_d = (state_d == S_DUMMY);
        busy_d  = (state_d != S_IDLE);
    end

    // state, counter and line-output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vact_q      <= 1'b0;
            vact_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 12'd0;
            line_q      <= 12'd0;
            gap_q       <= GAP_MAX;
            frame_q     <= 1'b0;
            hen_q       <= 1'b0;
            clamp_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vact_q      <= bus.vact;
            vact_prev_q <= vact_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            gap_q       <= gap_d;
            frame_q     <= frame_d;
            hen_q       <= hen_d;
            clamp_q     <= clamp_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // ADC_LAT-1 internal delay stages; the output registers form the last stage
    generate
        if (ADC_LAT == 1) begin : g_lat1
            assign feed = s0;
        end else begin : g_pipe
            strobe_t pipe_q [0:ADC_LAT-2];
            strobe_t pipe_d [0:ADC_LAT-2];

            // shift the strobes along, stripping eol from a line that is aborting
            always_comb begin
                pipe_d[0] = s0;
                for (int k = 1; k < ADC_LAT - 1; k++) begin
                    pipe_d[k]     = pipe_q[k-1];
                    pipe_d[k].eol = pipe_q[k-1].eol & ~abort;
                end
            end

            // delay-line registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '{default: '0};
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign feed = pipe_q[ADC_LAT-2];
        end
    endgenerate

    // final stage: qualify markers, hold coordinates and data between valid pixels
    always_comb begin
        pv_d   = feed.v;
        sof_d  = feed.v & feed.sof;
        eol_d  = feed.v & feed.eol & ~abort;
        px_d   = feed.v ? feed.x    : px_q;
        py_d   = feed.v ? feed.y    : py_q;
        data_d = feed.v ? bus.adc_d : data_q;
    end

    // pixel output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q   <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            px_q   <= 12'd0;
            py_q   <= 12'd0;
            data_q <= 14'd0;
        end else begin
            pv_q   <= pv_d;
            sof_q  <= sof_d;
            eol_q  <= eol_d;
            px_q   <= px_d;
            py_q   <= py_d;
            data_q <= data_d;
        end
    end

    assign bus.hen       = hen_q;
    assign bus.clamp     = clamp_q;
    assign bus.busy      = busy_q;
    assign bus.line_err  = err_q;
    assign bus.pix_valid = pv_q;
    assign bus.pix_data  = data_q;
    assign bus.pix_x     = px_q;
    assign bus.pix_y     = py_q;
    assign bus.sof       = sof_q;
    assign bus.eol       = eol_q;

endmodule

// File: tb/tb_tim_hfsm.sv
// tb/tb_tim_hfsm.sv - directed bench for the horizontal timing FSM
module tb_tim_hfsm;

    localparam int H_DUMMY = 4;
    localparam int H_ACTIVE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    tim_hfsm_if bus ();

    tim_hfsm #(
        .H_DUMMY   (4),
        .H_ACTIVE  (8),
        .H_OVER    (2),
        .FRAME_GAP (16),
        .ADC_LAT   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.adc_d = cyc[13:0];

    int n_cmp = 0;
    int n_bad = 0;

    int hen_cnt, hen_first, hen_last;
    int clamp_cnt, clamp_first, clamp_last;
    int busy_cnt, err_cnt, err_idx;
    int v_cnt, v_first, sof_mask, eol_mask, stray, data_bad;
    int xs[$];
    int ys[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        hen_cnt = 0; hen_first = -1; hen_last = -1;
        clamp_cnt = 0; clamp_first = -1; clamp_last = -1;
        busy_cnt = 0; err_cnt = 0; err_idx = -1;
        v_cnt = 0; v_first = -1; sof_mask = 0; eol_mask = 0; stray = 0; data_bad = 0;
        xs.delete();
        ys.delete();
    endtask

    // k = number of clock edges since vact was first driven for this line
    task automatic sample(input int k);
        if (bus.hen) begin
            if (hen_cnt == 0) hen_first = k;
            hen_last = k;
            hen_cnt++;
        end
        if (bus.clamp) begin
            if (clamp_cnt == 0) clamp_first = k;
            clamp_last = k;
            clamp_cnt++;
        end
        if (bus.busy) busy_cnt++;
        if (bus.line_err) begin
            err_cnt++;
            err_idx = k;
        end
        if (bus.pix_valid) begin
            if (v_cnt == 0) v_first = k;
            if (bus.sof) sof_mask |= (1 << v_cnt);
            if (bus.eol) eol_mask |= (1 << v_cnt);
            xs.push_back(int'(bus.pix_x));
            ys.push_back(int'(bus.pix_y));
            if (bus.pix_data != 14'(cyc - 1)) data_bad++;
            v_cnt++;
        end else if (bus.sof || bus.eol) begin
            stray++;
        end
    endtask

    task automatic run_line(input int n_high, input int n_low);
        clear_stats();
        for (int i = 0; i < n_high + n_low; i++) begin
            bus.vact = (i < n_high);
            @(negedge clk);
            sample(i + 1);
        end
    endtask

    task automatic check_line(input string nm, input int e_hen, input int e_busy,
                              input int e_valid, input int e_y, input int e_sof,
                              input int e_eol, input int e_err);
        check_val({nm, ".hen_cnt"}, hen_cnt, e_hen);
        check_val({nm, ".hen_first"}, hen_first, 2);
        check_val({nm, ".hen_span"}, hen_last - hen_first + 1, e_hen);
        check_val({nm, ".clamp_cnt"}, clamp_cnt, H_DUMMY);
        check_val({nm, ".clamp_first"}, clamp_first, 2);
        check_val({nm, ".clamp_last"}, clamp_last, 2 + H_DUMMY - 1);
        check_val({nm, ".busy_cnt"}, busy_cnt, e_busy);
        check_val({nm, ".valid_cnt"}, v_cnt, e_valid);
        check_val({nm, ".valid_first"}, v_first, 9);
        for (int i = 0; i < xs.size(); i++) begin
            check_val($sformatf("%s.x[%0d]", nm, i), xs[i], i);
            check_val($sformatf("%s.y[%0d]", nm, i), ys[i], e_y);
        end
        check_val({nm, ".sof_mask"}, sof_mask, e_sof);
        check_val({nm, ".eol_mask"}, eol_mask, e_eol);
        check_val({nm, ".err_cnt"}, err_cnt, e_err);
        if (e_err != 0) check_val({nm, ".err_idx"}, err_idx, 2 + e_hen);
        check_val({nm, ".data_bad"}, data_bad, 0);
        check_val({nm, ".stray_marker"}, stray, 0);
    endtask

    task automatic check_all_zero(input string nm);
        check_val({nm, ".hen"}, int'(bus.hen), 0);
        check_val({nm, ".clamp"}, int'(bus.clamp), 0);
        check_val({nm, ".busy"}, int'(bus.busy), 0);
        check_val({nm, ".pix_valid"}, int'(bus.pix_valid), 0);
        check_val({nm, ".pix_data"}, int'(bus.pix_data), 0);
        check_val({nm, ".pix_x"}, int'(bus.pix_x), 0);
        check_val({nm, ".pix_y"}, int'(bus.pix_y), 0);
        check_val({nm, ".sof"}, int'(bus.sof), 0);
        check_val({nm, ".eol"}, int'(bus.eol), 0);
        check_val({nm, ".line_err"}, int'(bus.line_err), 0);
    endtask

    initial begin
        bus.vact = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // single line after reset: frame start, y=0
        run_line(30, 5);
        check_line("line_a", 14, 30, 8, 0, 'h01, 'h80, 0);
        // short gaps: y advances, no sof
        run_line(30, 5);
        check_line("line_b", 14, 30, 8, 1, 0, 'h80, 0);
        run_line(30, 20);
        check_line("line_c", 14, 30, 8, 2, 0, 'h80, 0);
        // long gap before this one: new frame
        run_line(30, 5);
        check_line("line_d", 14, 30, 8, 0, 'h01, 'h80, 0);
        // abort after 6 hen cycles: x=0,1 drain, no eol, line_err once
        run_line(6, 5);
        check_line("abort", 6, 6, 2, 1, 0, 0, 1);
        // line after abort keeps the same y
        run_line(30, 5);
        check_line("line_f", 14, 30, 8, 1, 0, 'h80, 0);
        // vact held long: one line only, DONE keeps hen low while busy
        run_line(100, 5);
        check_line("long_vact", 14, 100, 8, 2, 0, 'h80, 0);

        // reset in the middle of ACTIVE
        for (int i = 0; i < 8; i++) begin
            bus.vact = 1'b1;
            @(negedge clk);
        end
        check_val("pre_rst.hen", int'(bus.hen), 1);
        rst = 1'b1;
        bus.vact = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        run_line(0, 6);
        check_val("post_rst.err_cnt", err_cnt, 0);
        check_val("post_rst.valid_cnt", v_cnt, 0);
        check_val("post_rst.busy_cnt", busy_cnt, 0);
        run_line(30, 5);
        check_line("after_rst", 14, 30, 8, 0, 'h01, 'h80, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tim_hfsm.md
Name: tim_hfsm

Overview:
- Horizontal timing and pixel-capture FSM. It is the line-level consumer of the vertical FSM's vact output.
- On each vact-high line window it gates the horizontal CCD clocks and the ADC for one line: dummy, then active, then overclock pixels. One pixel per PIXCLK cycle.
- It tags ADC samples with x/y coordinates and frame/line markers for the downstream pixel path.
- Sits between the vertical timing FSM, the CCD horizontal driver (ODDR clock gating) and the frame writer.

Parameters:
- H_DUMMY, 12, leading dummy/dark pixels per line (>=1)
- H_ACTIVE, 2472, active pixels per line (>=1, <=4096)
- H_OVER, 8, trailing overclock pixels (>=1)
- FRAME_GAP, 1024, vact-low cycles (>=2) after which the next line is line 0 of a new frame
- ADC_LAT, 3, ADC pipeline latency in cycles (>=1)

Ports:
- clk  in  1  PIXCLK 30 MHz
- rst  in  1  synchronous, active-high reset
- vact  in  1  line-active window from the vertical FSM
- adc_d  in  14  ADC sample bus
- hen  out  1  horizontal clock enable (H1/H2/RG gated externally)
- clamp  out  1  black-level clamp, high during dummy pixels
- busy  out  1  high in any state other than IDLE
- pix_valid  out  1  active pixel qualifier
- pix_data  out  14  pixel sample
- pix_x  out  12  active pixel index, 0..H_ACTIVE-1
- pix_y  out  12  line index within frame
- sof  out  1  with pix_valid on pixel (0,0)
- eol  out  1  with pix_valid on last pixel of line
- line_err  out  1  one-cycle pulse when a line aborts

Behaviour:
- Reset: all outputs 0, state IDLE, line counter 0. Gap counter = FRAME_GAP, so the first line after reset is a frame start. Pipeline is flushed.
- vact is registered once (vact_q). A start is the cycle where vact_q=1 and the previous vact_q=0.
- States and transitions:
  - IDLE: on start, go to DUMMY with pixel counter 0.
    - If gap counter >= FRAME_GAP: line counter <= 0 and a frame-start flag is set.
    - Gap counter is cleared on start. It increments (saturating at FRAME_GAP) each IDLE/DONE cycle with vact_q=0.
  - DUMMY: hen=1, clamp=1, for H_DUMMY cycles, then ACTIVE.
  - ACTIVE: hen=1, for H_ACTIVE cycles. Each cycle issues a strobe carrying x = counter, y = line counter, sof = (frame flag and x=0), eol = (x = H_ACTIVE-1). Frame flag clears after x=0.
  - OVER: hen=1, for H_OVER cycles. Line counter then increments, saturating at 4095. Go to DONE.
  - DONE: hen=0. Wait for vact_q=0, then IDLE. A re-rise of vact without vact_q going low first is ignored.
- Abort: vact_q=0 while in DUMMY/ACTIVE/OVER →
  - line_err pulses for 1 cycle and state goes to IDLE.
  - Strobes already issued still drain through the pipeline, but eol is not emitted for the aborted line.
  - Line counter does not increment.
- Output pipeline: an ADC_LAT-deep shift register carries strobe/x/y/sof/eol.
  - A strobe issued in cycle c appears on pix_valid/pix_x/pix_y/sof/eol in cycle c+ADC_LAT.
  - pix_data is registered from adc_d on the same edge, i.e. it is the adc_d value present in cycle c+ADC_LAT-1.
  - When pix_valid=0, sof and eol are 0; pix_x, pix_y and pix_data are don't-care but must be held.
- Line timing: total line = 1 (vact register) + 1 (start) + H_DUMMY + H_ACTIVE + H_OVER cycles after vact rises. Default 2492 pixels match the vertical FSM line length.
- Reset mid-line: immediate return to reset values. No line_err and no drain.
- Widths: counters are 12 bits. Parameter values exceeding 4096 are illegal.

Test Plan (bench params: H_DUMMY=4, H_ACTIVE=8, H_OVER=2, FRAME_GAP=16, ADC_LAT=3; adc_d = cycle count):
- Reset, then vact high for 30 cycles → hen high for 14 consecutive cycles; clamp for the first 4 of them; 8 pix_valid with pix_x 0..7 and pix_y=0; sof on x=0, eol on x=7; pix_data = adc_d of the preceding cycle.
- Three lines separated by 5-cycle vact-low gaps → pix_y = 0,1,2; sof only on line 0.
- Gap of 20 low cycles before the fourth line → pix_y = 0 and sof asserted again.
- vact drops after 6 hen cycles → line_err pulses once; exactly 2 pix_valid (x=0,1) drain, with no eol; next line keeps the same pix_y.
- vact held high for 100 cycles → only one line emitted; DONE holds hen=0 until vact falls.
- rst asserted during ACTIVE → next cycle all outputs 0, no line_err; next line has sof with pix_y=0.
